// File: rtl/fir_coeff_loader.sv
// Double-buffered coefficient loader for the fir filter: collects one frame of N
// signed words into a shadow bank and commits it atomically on a swap_ok cycle.
module fir_coeff_loader #(
  parameter int BITWIDTH = 16,
  parameter int N        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  input  logic [BITWIDTH-1:0]   load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic                  swap_ok,
  output logic [BITWIDTH*N-1:0] coeffs,
  output logic                  coeffs_valid,
  output logic                  swapped,
  output logic                  frame_err
);

  localparam int              CNT_W   = (N > 2) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PEND  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BITWIDTH-1:0]  shadow_q [N];
  logic [BITWIDTH-1:0]  shadow_d [N];
  logic [BITWIDTH*N-1:0] coeffs_q, coeffs_d;
  logic                 coeffs_valid_q, coeffs_valid_d;
  logic                 swapped_q, swapped_d;
  logic                 frame_err_q, frame_err_d;
  logic                 accept;
  logic                 shadow_we;
  logic                 commit;

  // Ready depends only on state and reset, so upstream can never see a
  // combinational path from its own load_valid.
  assign load_ready = rst_n && (state_q != PEND);
  assign accept     = load_valid && load_ready;

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_we   = 1'b0;
    commit      = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      FILL: begin
        if (accept) begin
          shadow_we = 1'b1;
          if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            if (load_last) begin
              state_d = PEND;
            end else begin
              frame_err_d = 1'b1;
              state_d     = DRAIN;
            end
          end else if (load_last) begin
            frame_err_d = 1'b1;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (accept && load_last) begin
          state_d = FILL;
        end
      end
      PEND: begin
        // Entry into PEND always lasts at least one cycle: swap_ok is only
        // looked at once the state register already holds PEND.
        if (swap_ok) begin
          commit  = 1'b1;
          state_d = FILL;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    if (shadow_we) begin
      shadow_d[cnt_q] = load_data;
    end
  end

  always_comb begin
    coeffs_d       = coeffs_q;
    coeffs_valid_d = coeffs_valid_q || commit;
    swapped_d      = commit;
    if (commit) begin
      for (int i = 0; i < N; i++) begin
        coeffs_d[BITWIDTH*i +: BITWIDTH] = shadow_q[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FILL;
      cnt_q          <= '0;
      coeffs_q       <= '0;
      coeffs_valid_q <= 1'b0;
      swapped_q      <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      coeffs_q       <= coeffs_d;
      coeffs_valid_q <= coeffs_valid_d;
      swapped_q      <= swapped_d;
      frame_err_q    <= frame_err_d;
    end
  end

  // NOTE: the shadow bank is deliberately left out of reset; a full frame
  // overwrites every entry before it can ever reach coeffs.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign coeffs       = coeffs_q;
  assign coeffs_valid = coeffs_valid_q;
  assign swapped      = swapped_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: reset, frame loads, held swap, short/long
// frames, gapped input and mid-frame reset.
module tb_fir_coeff_loader;

  localparam int W = 16;
  localparam int N = 16;

  logic             clk;
  logic             rst_n;
  logic             load_valid;
  logic [W-1:0]     load_data;
  logic             load_last;
  logic             load_ready;
  logic             swap_ok;
  logic [W*N-1:0]   coeffs;
  logic             coeffs_valid;
  logic             swapped;
  logic             frame_err;

  int checks = 0;
  int errors = 0;
  logic [W*N-1:0] cur_bank;

  fir_coeff_loader #(.BITWIDTH(W), .N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .swap_ok      (swap_ok),
    .coeffs       (coeffs),
    .coeffs_valid (coeffs_valid),
    .swapped      (swapped),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W*N-1:0] make_bank(input logic [W-1:0] base, input logic [W-1:0] step);
    logic [W*N-1:0] b;
    for (int i = 0; i < N; i++) b[W*i +: W] = base + W'(i) * step;
    return b;
  endfunction

  // Sends count words base, base+step, ...; optional idle gaps before each word.
  task automatic send_frame(input logic [W-1:0] base, input logic [W-1:0] step,
                            input int count, input bit with_last, input bit gaps);
    for (int i = 0; i < count; i++) begin
      if (gaps) begin
        int idle;
        idle = $urandom_range(0, 2);
        load_valid = 1'b0;
        for (int g = 0; g < idle; g++) tick();
      end
      load_valid = 1'b1;
      load_data  = base + W'(i) * step;
      load_last  = with_last && (i == count - 1);
      checks++;
      if (load_ready !== 1'b1) begin
        errors++;
        $display("FAIL ready_before_word[%0d]: got %b expected 1", i, load_ready);
      end
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Called right after the last word's edge with swap_ok=1.
  task automatic expect_commit(input logic [W*N-1:0] exp, input string name);
    checks++;
    if (swapped !== 1'b0 || load_ready !== 1'b0 || coeffs !== cur_bank) begin
      errors++;
      $display("FAIL %s_pend: swapped=%b ready=%b coeffs=%h expected swapped=0 ready=0 coeffs=%h",
               name, swapped, load_ready, coeffs, cur_bank);
    end
    tick();
    checks++;
    if (swapped !== 1'b1 || coeffs_valid !== 1'b1 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_swap: swapped=%b valid=%b ready=%b expected 1 1 1",
               name, swapped, coeffs_valid, load_ready);
    end
    checks++;
    if (coeffs !== exp) begin
      errors++;
      $display("FAIL %s_bank: got %h expected %h", name, coeffs, exp);
    end
    tick();
    checks++;
    if (swapped !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse_end: got %b expected 0", name, swapped);
    end
    cur_bank = exp;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    load_valid = 1'b1;
    load_data  = 16'h55AA;
    load_last  = 1'b1;
    swap_ok    = 1'b1;
    cur_bank   = '0;
    repeat (3) tick();
    checks++;
    if (load_ready !== 1'b0 || coeffs !== '0 || coeffs_valid !== 1'b0 ||
        swapped !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: ready=%b coeffs=%h valid=%b swapped=%b err=%b expected all 0",
               load_ready, coeffs, coeffs_valid, swapped, frame_err);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    rst_n      = 1'b1;
    #1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", load_ready);
    end
    repeat (3) tick();
    checks++;
    if (coeffs_valid !== 1'b0 || swapped !== 1'b0 || coeffs !== '0) begin
      errors++;
      $display("FAIL reset_no_capture: valid=%b swapped=%b coeffs=%h expected 0 0 0",
               coeffs_valid, swapped, coeffs);
    end
  endtask

  task automatic test_basic_load();
    swap_ok = 1'b1;
    send_frame(16'h0000, 16'h0001, N, 1'b1, 1'b0);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_no_err: got %b expected 0", frame_err);
    end
    expect_commit(make_bank(16'h0000, 16'h0001), "basic_ramp");
    send_frame(16'hFFFF, 16'hFFFF, N, 1'b1, 1'b0);
    expect_commit(make_bank(16'hFFFF, 16'hFFFF), "basic_neg");
  endtask

  task automatic test_held_swap();
    logic [W*N-1:0] exp;
    bit bad;
    exp     = make_bank(16'h1000, 16'h0011);
    swap_ok = 1'b0;
    send_frame(16'h1000, 16'h0011, N, 1'b1, 1'b0);
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (load_ready !== 1'b0 || swapped !== 1'b0 || coeffs !== cur_bank) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL held_pend: ready=%b swapped=%b coeffs=%h expected 0 0 %h",
               load_ready, swapped, coeffs, cur_bank);
    end
    swap_ok = 1'b1;
    tick();
    checks++;
    if (swapped !== 1'b1 || coeffs !== exp) begin
      errors++;
      $display("FAIL held_release: swapped=%b coeffs=%h expected 1 %h", swapped, coeffs, exp);
    end
    tick();
    checks++;
    if (swapped !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL held_single_pulse: swapped=%b ready=%b expected 0 1", swapped, load_ready);
    end
    cur_bank = exp;
  endtask

  task automatic test_short_frame();
    send_frame(16'h7000, 16'h0001, 6, 1'b1, 1'b0);
    checks++;
    if (frame_err !== 1'b1 || load_ready !== 1'b1 || coeffs !== cur_bank) begin
      errors++;
      $display("FAIL short_err: err=%b ready=%b coeffs=%h expected 1 1 %h",
               frame_err, load_ready, coeffs, cur_bank);
    end
    tick();
    checks++;
    if (frame_err !== 1'b0 || swapped !== 1'b0) begin
      errors++;
      $display("FAIL short_err_pulse: err=%b swapped=%b expected 0 0", frame_err, swapped);
    end
    send_frame(16'h2000, 16'h0003, N, 1'b1, 1'b0);
    expect_commit(make_bank(16'h2000, 16'h0003), "short_recover");
  endtask

  task automatic test_long_frame();
    bit bad;
    send_frame(16'h8000, 16'h0001, N, 1'b0, 1'b0);
    checks++;
    if (frame_err !== 1'b1 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL long_err: err=%b ready=%b expected 1 1", frame_err, load_ready);
    end
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = 16'hDEAD + W'(i);
      load_last  = (i == 2);
      tick();
      if (frame_err !== 1'b0 || swapped !== 1'b0 || load_ready !== 1'b1) bad = 1'b1;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    checks++;
    if (bad || coeffs !== cur_bank) begin
      errors++;
      $display("FAIL long_drain: err=%b swapped=%b ready=%b coeffs=%h expected 0 0 1 %h",
               frame_err, swapped, load_ready, coeffs, cur_bank);
    end
    send_frame(16'h4000, 16'h0101, N, 1'b1, 1'b0);
    expect_commit(make_bank(16'h4000, 16'h0101), "long_recover");
  endtask

  task automatic test_backpressure_reset();
    send_frame(16'h3000, 16'h0002, N, 1'b1, 1'b1);
    expect_commit(make_bank(16'h3000, 16'h0002), "gapped");
    send_frame(16'h5000, 16'h0001, 8, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (coeffs !== '0 || coeffs_valid !== 1'b0 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset: coeffs=%h valid=%b ready=%b expected 0 0 0",
               coeffs, coeffs_valid, load_ready);
    end
    cur_bank = '0;
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(16'd100, 16'h0001, N, 1'b1, 1'b0);
    expect_commit(make_bank(16'd100, 16'h0001), "after_reset");
  endtask

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    swap_ok    = 1'b0;
    test_reset();
    test_basic_load();
    test_held_swap();
    test_short_frame();
    test_long_frame();
    test_backpressure_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Coefficient writer for the `fir` filter. It accepts a stream of `N` signed coefficient words over a valid/ready handshake and collects them in a shadow bank. It commits the bank atomically to the flattened `coeffs` bus that feeds the FIR's coefficient port, and the swap happens only on a cycle the filter marks as safe. This replaces the constant `cs[i] = i` tie-off with a runtime-loadable, double-buffered coefficient set.

## Interface
- `BITWIDTH`, 16, width of one signed coefficient word (same as the FIR `BITWIDTH`).
- `N`, 16, number of taps / coefficients per frame; N ≥ 2.
- `clk`  in  1  rising-edge clock, shared with `fir`.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `load_valid`  in  1  upstream has a coefficient word on `load_data`.
- `load_data`  in  BITWIDTH  signed coefficient word; frame order is tap 0 first.
- `load_last`  in  1  marks the final word of a frame; sampled only when a word is accepted.
- `load_ready`  out  1  loader can accept a word this cycle.
- `swap_ok`  in  1  FIR sample boundary / idle; a commit is allowed at the end of this cycle.
- `coeffs`  out  BITWIDTH*N  active bank; tap i is at `[BITWIDTH*(i+1)-1 : BITWIDTH*i]`.
- `coeffs_valid`  out  1  at least one frame has been committed since reset.
- `swapped`  out  1  single-cycle pulse: `coeffs` took a new bank at the last edge.
- `frame_err`  out  1  single-cycle pulse: a malformed frame was detected and discarded.

## Operation
- Word accepted ⇔ `load_valid && load_ready` at a rising edge.
- Internal tap counter `cnt` ranges 0..N-1.
- State machine states: FILL, PEND, DRAIN; state after reset is FILL with `cnt=0`.
- FILL:
  - `load_ready=1`.
  - An accepted word is written to `shadow[cnt]`.
  - Accepted with `load_last=1` and `cnt==N-1`: go to PEND with `cnt←0`.
  - Accepted with `load_last=1` and `cnt<N-1` (short frame): pulse `frame_err`, set `cnt←0`, stay in FILL.
  - Accepted with `load_last=0` and `cnt==N-1` (long frame): pulse `frame_err`, set `cnt←0`, go to DRAIN.
  - Otherwise: `cnt←cnt+1`.
- DRAIN:
  - `load_ready=1`.
  - Accepted words are discarded.
  - An accepted word with `load_last=1`: go to FILL.
  - No further `frame_err` pulses are raised in DRAIN.
- PEND:
  - `load_ready=0`.
  - Shadow bank is held.
  - `swap_ok=1` at an edge: `coeffs←shadow` (all N taps in the same edge), `coeffs_valid←1`, `swapped` pulses, go to FILL.
  - `swap_ok=0`: remain in PEND indefinitely.
- Coefficients are copied bit-exact; no arithmetic, scaling or sign handling is performed.
- `coeffs` changes only on a PEND→FILL commit or on reset. The FIR never sees a partially updated bank.
- Reset mid-operation:
  - Any partial frame and any pending shadow are discarded.
  - Shadow storage contents need not be reset; they are never visible before a full frame overwrites every entry.

## Timing
- Reset values:
  - `coeffs=0`, `coeffs_valid=0`, `swapped=0`, `frame_err=0`.
  - `load_ready=0` while `rst_n=0` (gated combinationally by `rst_n`); it is 1 in the first cycle after deassertion.
- `load_ready` is combinational from state (and `rst_n`) only, never from `load_valid`.
- `swapped`, `frame_err` and `coeffs_valid` are registered.
- Commit latency:
  - Last word accepted at edge k.
  - PEND occupies cycle k→k+1, so `swap_ok` is first sampled at edge k+1.
  - If `swap_ok=1` then, `coeffs` updates and `swapped=1` after edge k+1.
  - Minimum last-word-to-new-coeffs latency is 2 edges.
- Minimum PEND dwell is one cycle, even if `swap_ok` is already high on entry.
- Throughput: one word per cycle in FILL/DRAIN. A full frame followed by an immediate swap takes N+1 cycles per frame.
- `frame_err` asserts in the cycle after the offending word's edge, for exactly one cycle.
- `load_valid` gaps are allowed anywhere; `cnt` holds across gaps.

## Test plan
- Reset:
  - Hold `rst_n=0` for 3 cycles with `load_valid=1` → `load_ready=0`, `coeffs=0`, `coeffs_valid=0`, no word captured.
  - Release → `load_ready=1` next cycle.
- Basic load (N=16, BITWIDTH=16):
  - Send words 0..15 back-to-back, `load_last` on word 15, `swap_ok=1` held → `swapped` pulses 2 edges after the last word.
  - Result: tap i = i, `coeffs_valid=1`; this must match the old `cs[i]=i` behaviour.
  - Repeat with -1..-16 → tap i = 16'hFFFF-i.
- Held swap:
  - Full frame with `swap_ok=0` for 10 cycles → `load_ready=0`, `coeffs` unchanged, no `swapped` pulse.
  - Raise `swap_ok` → exactly one `swapped` pulse and the new bank appears at that edge.
- Short frame:
  - `load_last` on word 5 → `frame_err` pulse, `coeffs` unchanged.
  - A following correct 16-word frame commits normally.
- Long frame:
  - 16 words without `load_last` → `frame_err` pulse after word 16, enter DRAIN.
  - Next 3 words (last on 3rd) are discarded, with no `swapped` pulse.
  - A following correct frame commits normally.
- Backpressure and mid-frame reset:
  - Frame with random `load_valid` gaps → same result as back-to-back.
  - Assert `rst_n` after 8 words → `coeffs=0`.
  - Then a full frame 100..115 commits taps 100..115.
